// File: rtl/vga_pattern_gen.sv
// Parametrised VGA timing and test-pattern generator. Raster counters, sync
// generation and four frame-latched test patterns; every output is registered.
module vga_pattern_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_NEG   = 1,
    parameter int COLOR_BITS = 4,
    parameter int CLK_DIV    = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                mode,
    input  logic [3*COLOR_BITS-1:0]   solid_rgb,
    output logic                      vga_h_sync,
    output logic                      vga_v_sync,
    output logic [COLOR_BITS-1:0]     vga_r,
    output logic [COLOR_BITS-1:0]     vga_g,
    output logic [COLOR_BITS-1:0]     vga_b,
    output logic                      active,
    output logic                      frame_start,
    output logic [7:0]                frame_count
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW       = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW       = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int BAR_W    = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    localparam logic [DW-1:0]         DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0]         H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0]         V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [COLOR_BITS-1:0] C_MAX     = '1;
    localparam logic                  SYNC_IDLE = (SYNC_NEG != 0);

    typedef enum logic [1:0] {
        PAT_SOLID    = 2'd0,
        PAT_BARS     = 2'd1,
        PAT_CHECKER  = 2'd2,
        PAT_GRADIENT = 2'd3
    } pattern_e;

    // Raster state
    logic [DW-1:0]          div_cnt_q, div_cnt_d;
    logic [HW-1:0]          h_cnt_q, h_cnt_d;
    logic [VW-1:0]          v_cnt_q, v_cnt_d;
    logic [7:0]             frame_count_q, frame_count_d;
    pattern_e               mode_q, mode_d;

    // Registered outputs
    logic                   hs_q, hs_d;
    logic                   vs_q, vs_d;
    logic [COLOR_BITS-1:0]  r_q, r_d;
    logic [COLOR_BITS-1:0]  g_q, g_d;
    logic [COLOR_BITS-1:0]  b_q, b_d;
    logic                   active_q, active_d;
    logic                   frame_start_q, frame_start_d;

    // Per-pixel combinational values
    logic                   pix_en;
    logic                   at_origin;
    logic                   line_end;
    logic                   frame_end;
    pattern_e               pix_mode;
    logic [31:0]            h_ext;
    logic [31:0]            v_ext;
    logic                   hs_on;
    logic                   vs_on;
    logic                   visible;
    logic [2:0]             bar_idx;
    logic                   checker_on;
    logic [COLOR_BITS-1:0]  pat_r, pat_g, pat_b;

    always_comb begin : counter_next
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        pix_en        = (div_cnt_q == DIV_LAST);
        at_origin     = (h_cnt_q == '0) && (v_cnt_q == '0);
        line_end      = (h_cnt_q == H_LAST);
        frame_end     = line_end && (v_cnt_q == V_LAST);

        div_cnt_d     = pix_en ? '0 : div_cnt_q + DW'(1);
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        frame_count_d = frame_count_q;
        mode_d        = mode_q;

        if (pix_en) begin
            h_cnt_d = line_end ? '0 : h_cnt_q + HW'(1);
            if (line_end) begin
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
            end
            if (frame_end) begin
                frame_count_d = frame_count_q + 8'd1;
            end
            // Pattern changes are only accepted at the top-left pixel so a frame never tears.
            if (at_origin) begin
                mode_d = pattern_e'(mode);
            end
        end
    end

    always_comb begin : pixel_values
        pix_mode   = at_origin ? pattern_e'(mode) : mode_q;
        h_ext      = 32'(h_cnt_q);
        v_ext      = 32'(v_cnt_q);

        hs_on      = (h_ext >= HS_START) && (h_ext < HS_END);
        vs_on      = (v_ext >= VS_START) && (v_ext < VS_END);
        visible    = (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);

        bar_idx    = ((h_ext / BAR_W) > 32'd7) ? 3'd7 : 3'(h_ext / BAR_W);
        checker_on = h_ext[3] ^ v_ext[3];

        pat_r = '0;
        pat_g = '0;
        pat_b = '0;
        if (visible) begin
            case (pix_mode)
                PAT_SOLID: begin
                    pat_r = solid_rgb[3*COLOR_BITS-1 -: COLOR_BITS];
                    pat_g = solid_rgb[2*COLOR_BITS-1 -: COLOR_BITS];
                    pat_b = solid_rgb[COLOR_BITS-1 -: COLOR_BITS];
                end
                PAT_BARS: begin
                    pat_r = bar_idx[2] ? C_MAX : '0;
                    pat_g = bar_idx[1] ? C_MAX : '0;
                    pat_b = bar_idx[0] ? C_MAX : '0;
                end
                PAT_CHECKER: begin
                    pat_r = checker_on ? C_MAX : '0;
                    pat_g = checker_on ? C_MAX : '0;
                    pat_b = checker_on ? C_MAX : '0;
                end
                PAT_GRADIENT: begin
                    // Truncating each term first gives the same low bits as truncating the sum.
                    pat_r = COLOR_BITS'(h_ext >> 4) + COLOR_BITS'(frame_count_q);
                    pat_g = COLOR_BITS'(v_ext >> 4);
                end
                default: ;
            endcase
        end
    end

    always_comb begin : output_next
        hs_d          = hs_q;
        vs_d          = vs_q;
        r_d           = r_q;
        g_d           = g_q;
        b_d           = b_q;
        active_d      = active_q;
        frame_start_d = 1'b0;

        if (pix_en) begin
            hs_d          = hs_on ^ SYNC_IDLE;
            vs_d          = vs_on ^ SYNC_IDLE;
            r_d           = pat_r;
            g_d           = pat_g;
            b_d           = pat_b;
            active_d      = visible;
            frame_start_d = at_origin;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every flop sample pre-edge values, so register order in this block does not matter.
        if (reset) begin
            div_cnt_q     <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            frame_count_q <= '0;
            mode_q        <= PAT_SOLID;
            hs_q          <= SYNC_IDLE;
            vs_q          <= SYNC_IDLE;
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
            active_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_count_q <= frame_count_d;
            mode_q        <= mode_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
            active_q      <= active_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga_h_sync  = hs_q;
    assign vga_v_sync  = vs_q;
    assign vga_r       = r_q;
    assign vga_g       = g_q;
    assign vga_b       = b_q;
    assign active      = active_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: three configurations, a pixel-index reference
// model scoring every clock, plus directed tables for bars, tearing and wrap.
module tb_vga_pattern_gen;

    localparam int CLK_PERIOD = 10;

    typedef struct {
        int ha, hfp, hsw, hbp;
        int va, vfp, vsw, vbp;
        int sneg, div;
    } cfg_t;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic       act;
        logic       fs;
        logic [7:0] fc;
    } out_t;

    typedef struct {
        int         pix;
        logic [3:0] r, g, b;
        logic       act, hs, fs;
    } bar_vec_t;

    logic        clk = 1'b0;
    logic        rst_main;
    logic        rst_small;
    logic [1:0]  mode_def, mode_a, mode_s;
    logic [11:0] solid_main, solid_s;

    logic        d_hs [3];
    logic        d_vs [3];
    logic [3:0]  d_r  [3];
    logic [3:0]  d_g  [3];
    logic [3:0]  d_b  [3];
    logic        d_act[3];
    logic        d_fs [3];
    logic [7:0]  d_fc [3];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_main = -1;
    int cyc_s    = -1;

    int   m_e    [3];
    int   m_fmode[3];
    out_t m_exp  [3];
    bit   m_valid = 1'b0;

    always #(CLK_PERIOD / 2) clk = ~clk;

    vga_pattern_gen dut_def (
        .clk(clk), .reset(rst_main), .mode(mode_def), .solid_rgb(solid_main),
        .vga_h_sync(d_hs[0]), .vga_v_sync(d_vs[0]),
        .vga_r(d_r[0]), .vga_g(d_g[0]), .vga_b(d_b[0]),
        .active(d_act[0]), .frame_start(d_fs[0]), .frame_count(d_fc[0])
    );

    vga_pattern_gen #(
        .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) dut_a (
        .clk(clk), .reset(rst_main), .mode(mode_a), .solid_rgb(solid_main),
        .vga_h_sync(d_hs[1]), .vga_v_sync(d_vs[1]),
        .vga_r(d_r[1]), .vga_g(d_g[1]), .vga_b(d_b[1]),
        .active(d_act[1]), .frame_start(d_fs[1]), .frame_count(d_fc[1])
    );

    vga_pattern_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_NEG(0), .CLK_DIV(3)
    ) dut_s (
        .clk(clk), .reset(rst_small), .mode(mode_s), .solid_rgb(solid_s),
        .vga_h_sync(d_hs[2]), .vga_v_sync(d_vs[2]),
        .vga_r(d_r[2]), .vga_g(d_g[2]), .vga_b(d_b[2]),
        .active(d_act[2]), .frame_start(d_fs[2]), .frame_count(d_fc[2])
    );

    function automatic cfg_t cfg_of(int i);
        cfg_t c;
        case (i)
            0:       c = '{640, 16, 96, 48, 480, 10, 2, 33, 1, 1};
            1:       c = '{640, 16, 96, 48, 8, 2, 2, 2, 1, 1};
            default: c = '{8, 1, 2, 1, 4, 1, 2, 1, 0, 3};
        endcase
        return c;
    endfunction

    function automatic out_t mk(logic hs, logic vs, logic [3:0] r, logic [3:0] g,
                                logic [3:0] b, logic act, logic fs, logic [7:0] fc);
        out_t o;
        o.hs = hs; o.vs = vs; o.r = r; o.g = g; o.b = b;
        o.act = act; o.fs = fs; o.fc = fc;
        return o;
    endfunction

    function automatic out_t dut_out(int i);
        return mk(d_hs[i], d_vs[i], d_r[i], d_g[i], d_b[i], d_act[i], d_fs[i], d_fc[i]);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: edge e after reset release has loaded (e+1)/div pixels;
    // position, frame number and pattern follow directly from that pixel index.
    task automatic model_step(int i, logic rst, logic [1:0] md, logic [11:0] solid);
        cfg_t c;
        out_t o;
        int ht, vt, ft, p, n, f, w, h, v, k;
        logic chk;
        c = cfg_of(i);
        if (rst) begin
            m_e[i]   = -1;
            m_exp[i] = mk(c.sneg[0], c.sneg[0], 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00);
            return;
        end
        m_e[i]++;
        if ((m_e[i] + 1) % c.div != 0) begin
            m_exp[i].fs = 1'b0;
            return;
        end
        ht = c.ha + c.hfp + c.hsw + c.hbp;
        vt = c.va + c.vfp + c.vsw + c.vbp;
        ft = ht * vt;
        p  = (m_e[i] + 1) / c.div;
        n  = p - 1;
        f  = n / ft;
        w  = n % ft;
        h  = w % ht;
        v  = w / ht;
        if (h == 0 && v == 0) m_fmode[i] = md;
        o     = '0;
        o.hs  = ((h >= c.ha + c.hfp) && (h < c.ha + c.hfp + c.hsw)) ^ c.sneg[0];
        o.vs  = ((v >= c.va + c.vfp) && (v < c.va + c.vfp + c.vsw)) ^ c.sneg[0];
        o.act = (h < c.ha) && (v < c.va);
        o.fs  = (h == 0) && (v == 0);
        o.fc  = 8'((p / ft) % 256);
        if (o.act) begin
            case (m_fmode[i])
                0: begin
                    o.r = solid[11:8]; o.g = solid[7:4]; o.b = solid[3:0];
                end
                1: begin
                    k = h / ((c.ha / 8 > 0) ? c.ha / 8 : 1);
                    if (k > 7) k = 7;
                    o.r = k[2] ? 4'hF : 4'h0;
                    o.g = k[1] ? 4'hF : 4'h0;
                    o.b = k[0] ? 4'hF : 4'h0;
                end
                2: begin
                    chk = 1'(((h / 8) + (v / 8)) % 2);
                    o.r = chk ? 4'hF : 4'h0;
                    o.g = o.r;
                    o.b = o.r;
                end
                default: begin
                    o.r = 4'((h / 16) + (f % 256));
                    o.g = 4'(v / 16);
                end
            endcase
        end
        m_exp[i] = o;
    endtask

    always @(posedge clk) begin
        model_step(0, rst_main, mode_def, solid_main);
        model_step(1, rst_main, mode_a, solid_main);
        model_step(2, rst_small, mode_s, solid_s);
        m_valid  = 1'b1;
        cyc_main <= rst_main ? -1 : cyc_main + 1;
        cyc_s    <= rst_small ? -1 : cyc_s + 1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("scoreboard_dut%0d", i), 32'(dut_out(i)), 32'(m_exp[i]));
            end
        end
    end

    task automatic wait_main(int e);
        while (cyc_main < e) @(negedge clk);
    endtask

    task automatic wait_small(int e);
        while (cyc_s < e) @(negedge clk);
    endtask

    task automatic main_seq();
        bar_vec_t bars[15];
        bars = '{
            '{0,   4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1},
            '{1,   4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0},
            '{80,  4'h0, 4'h0, 4'hF, 1'b1, 1'b1, 1'b0},
            '{159, 4'h0, 4'h0, 4'hF, 1'b1, 1'b1, 1'b0},
            '{160, 4'h0, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0},
            '{400, 4'hF, 4'h0, 4'hF, 1'b1, 1'b1, 1'b0},
            '{560, 4'hF, 4'hF, 4'hF, 1'b1, 1'b1, 1'b0},
            '{639, 4'hF, 4'hF, 4'hF, 1'b1, 1'b1, 1'b0},
            '{640, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0},
            '{655, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0},
            '{656, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0},
            '{751, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0},
            '{752, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0},
            '{800, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0},
            '{880, 4'h0, 4'h0, 4'hF, 1'b1, 1'b1, 1'b0}
        };
        for (int i = 0; i < 15; i++) begin
            wait_main(bars[i].pix);
            check($sformatf("bars_pix%0d", bars[i].pix), 32'(dut_out(0)),
                  32'(mk(bars[i].hs, 1'b1, bars[i].r, bars[i].g, bars[i].b,
                         bars[i].act, bars[i].fs, 8'h00)));
        end

        // dut_a: checkerboard frame, switched to solid at line 4.
        wait_main(4 * 800);
        mode_a = 2'd0;
        wait_main(5 * 800 + 8);
        check("tear_chk_8_5", 32'(dut_out(1)), 32'(mk(1, 1, 4'hF, 4'hF, 4'hF, 1, 0, 8'd0)));
        wait_main(7 * 800 + 7);
        check("tear_chk_7_7", 32'(dut_out(1)), 32'(mk(1, 1, 4'h0, 4'h0, 4'h0, 1, 0, 8'd0)));
        wait_main(7 * 800 + 639);
        check("tear_chk_639_7", 32'(dut_out(1)), 32'(mk(1, 1, 4'hF, 4'hF, 4'hF, 1, 0, 8'd0)));
        wait_main(10 * 800);
        check("vsync_line10", 32'(dut_out(1)), 32'(mk(1, 0, 4'h0, 4'h0, 4'h0, 0, 0, 8'd0)));
        wait_main(12 * 800);
        check("vsync_line12", 32'(dut_out(1)), 32'(mk(1, 1, 4'h0, 4'h0, 4'h0, 0, 0, 8'd0)));
        wait_main(11199);
        check("last_pixel_fc", 32'(dut_out(1)), 32'(mk(1, 1, 4'h0, 4'h0, 4'h0, 0, 0, 8'd1)));
        wait_main(11200);
        check("solid_at_frame1", 32'(dut_out(1)), 32'(mk(1, 1, 4'h3, 4'hA, 4'h5, 1, 1, 8'd1)));
        wait_main(11208);
        check("solid_frame1_px8", 32'(dut_out(1)), 32'(mk(1, 1, 4'h3, 4'hA, 4'h5, 1, 0, 8'd1)));

        // Reset in the middle of a line.
        wait_main(11200 + 300);
        rst_main = 1'b1;
        repeat (3) @(negedge clk);
        check("midline_reset_def", 32'(dut_out(0)), 32'(mk(1, 1, 4'h0, 4'h0, 4'h0, 0, 0, 8'd0)));
        check("midline_reset_a", 32'(dut_out(1)), 32'(mk(1, 1, 4'h0, 4'h0, 4'h0, 0, 0, 8'd0)));
        rst_main = 1'b0;

        // Random modes, colours and occasional resets, scored by the model.
        for (int k = 0; k < 45000; k++) begin
            @(negedge clk);
            mode_def   = 2'($urandom);
            mode_a     = 2'($urandom);
            solid_main = 12'($urandom);
            rst_main   = ($urandom_range(0, 7999) == 0);
        end
        rst_main = 1'b0;
    endtask

    task automatic small_seq();
        wait_small(1);
        check("small_pre_pix", 32'(dut_out(2)), 32'(mk(0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 8'd0)));
        wait_small(2);
        check("small_pix0_e2", 32'(dut_out(2)), 32'(mk(0, 0, 4'h0, 4'h0, 4'h0, 1, 1, 8'd0)));
        wait_small(3);
        check("small_pix0_e3", 32'(dut_out(2)), 32'(mk(0, 0, 4'h0, 4'h0, 4'h0, 1, 0, 8'd0)));
        wait_small(4);
        check("small_pix0_e4", 32'(dut_out(2)), 32'(mk(0, 0, 4'h0, 4'h0, 4'h0, 1, 0, 8'd0)));
        wait_small(26);
        check("small_hs_pix8", 32'(dut_out(2)), 32'(mk(0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 8'd0)));
        wait_small(29);
        check("small_hs_pix9", 32'(dut_out(2)), 32'(mk(1, 0, 4'h0, 4'h0, 4'h0, 0, 0, 8'd0)));
        wait_small(35);
        check("small_hs_pix11", 32'(dut_out(2)), 32'(mk(0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 8'd0)));
        wait_small(182);
        check("small_vs_line5", 32'(dut_out(2)), 32'(mk(0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 8'd0)));
        wait_small(254);
        check("small_vs_line7", 32'(dut_out(2)), 32'(mk(0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 8'd0)));
        for (int f = 1; f <= 256; f++) begin
            wait_small(288 * f + 2);
            check($sformatf("small_frame%0d", f),
                  {19'd0, d_fs[2], d_r[2], d_fc[2]},
                  {19'd0, 1'b1, 4'(f % 16), 8'(f % 256)});
        end
    endtask

    initial begin
        rst_main   = 1'b1;
        rst_small  = 1'b1;
        mode_def   = 2'd1;
        mode_a     = 2'd2;
        mode_s     = 2'd3;
        solid_main = 12'h3A5;
        solid_s    = 12'($urandom);
        repeat (5) @(negedge clk);
        check("reset_def", 32'(dut_out(0)), 32'(mk(1, 1, 4'h0, 4'h0, 4'h0, 0, 0, 8'd0)));
        check("reset_a", 32'(dut_out(1)), 32'(mk(1, 1, 4'h0, 4'h0, 4'h0, 0, 0, 8'd0)));
        check("reset_small", 32'(dut_out(2)), 32'(mk(0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 8'd0)));
        rst_main  = 1'b0;
        rst_small = 1'b0;
        fork
            main_seq();
            small_seq();
        join
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #(CLK_PERIOD * 90000);
        $display("FAIL watchdog: run did not complete within %0d clocks", 90000);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

- Parametrised VGA timing and test-pattern generator; next generation of the fixed 640x480 VGA demo.
- Adds configurable timing, sync polarity, colour depth and pixel-clock division.
- Adds four runtime-selectable patterns, tear-free mode switching, a frame counter and a frame-start strobe.
- Sits inside the project wrapper, driving the io pads.
- `mode`/`solid_rgb` come from logic-analyser inputs.
- `frame_count` and `frame_start` go back to the logic analyser.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch/sync widths (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch/sync widths (lines)
- SYNC_NEG, 1, 1 = syncs active-low
- COLOR_BITS, 4, bits per colour channel (1..8)
- CLK_DIV, 1, clk cycles per pixel (>=1)

Ports:
- clk  in  1  single clock (wrapper connects wb_clk_i)
- reset  in  1  synchronous, active-high
- mode  in  2  pattern select: 0 solid, 1 colour bars, 2 checkerboard, 3 scrolling gradient
- solid_rgb  in  3*COLOR_BITS  {r,g,b} colour for mode 0
- vga_h_sync / vga_v_sync  out  1  sync outputs
- vga_r / vga_g / vga_b  out  COLOR_BITS  colour outputs
- active  out  1  high while output pixel is visible
- frame_start  out  1  one-clk pulse when outputs show pixel (0,0)
- frame_count  out  8  completed-frame counter

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Divider:
  - div_cnt counts 0..CLK_DIV-1.
  - pix_en is high when div_cnt==CLK_DIV-1.
  - CLK_DIV=1 gives pix_en every clk.
- Counters:
  - h_cnt, v_cnt address the current pixel and change only on pix_en.
  - h_cnt wraps at H_TOTAL-1 to 0 and increments v_cnt.
  - v_cnt wraps at V_TOTAL-1 to 0.
  - On the wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0), frame_count increments, 255 wraps to 0.
- On each pix_en, output registers load the values for pixel (h_cnt, v_cnt):
  - hs asserted iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs asserted iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC.
  - Pin level = asserted XOR SYNC_NEG.
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - When not active, r/g/b = 0 regardless of mode.
  - frame_start = 1 iff (h_cnt, v_cnt) == (0,0), else 0. Also cleared on any clk without pix_en, so it is a single-clk pulse.
- Mode latching:
  - mode is sampled into mode_q only on the pix_en where counters are (0,0).
  - That sampled value is already used for pixel (0,0).
  - Every other pixel uses mode_q, so there is no mid-frame tearing.
  - solid_rgb is used live, not latched.
- Patterns (M = 2^COLOR_BITS-1, all channels COLOR_BITS wide):
  - 0 solid: {r,g,b} = solid_rgb.
  - 1 bars:
    - BAR_W = H_ACTIVE/8 (integer division); k = min(h_cnt/BAR_W, 7).
    - r = k[2]?M:0, g = k[1]?M:0, b = k[0]?M:0.
  - 2 checker: c = h_cnt[3]^v_cnt[3]; r = g = b = c?M:0.
  - 3 gradient:
    - r = (h_cnt>>4) + frame_count, truncated to COLOR_BITS.
    - g = (v_cnt>>4) truncated to COLOR_BITS.
    - b = 0.
- Reset (clk edge with reset=1) sets:
  - div_cnt, h_cnt, v_cnt, frame_count, mode_q = 0.
  - r/g/b = 0, active = 0, frame_start = 0.
  - Syncs at deasserted level (SYNC_NEG ? 1 : 0).
- Reset mid-frame aborts the frame immediately. No partial-frame count.

## Timing
- Output latency: registered outputs reflect the pixel addressed on the previous pix_en clk edge.
- CLK_DIV=1, first clk after reset deasserts:
  - Outputs load pixel (0,0) and frame_start=1.
  - Subsequent pixel n appears n clks later.
- Outputs hold for CLK_DIV clks per pixel.
- Line period = H_TOTAL*CLK_DIV clks; frame period = H_TOTAL*V_TOTAL*CLK_DIV clks.
- Defaults: 800 clks/line, 420000 clks/frame.
- Mode change takes effect exactly at the next frame_start, never earlier.

## Test plan
- Reset values: hold reset 5 clks -> vga_h_sync=vga_v_sync=1, rgb=0, active=0, frame_start=0, frame_count=0. Same checks after reset asserted mid-line.
- Default timing, CLK_DIV=1:
  - frame_start at clk 0 after reset release.
  - vga_h_sync low during clks 656..751 of each line, period 800.
  - active high clks 0..639.
  - vga_v_sync low during lines 490..491.
  - Next frame_start at clk 420000 with frame_count=1.
- Colour bars, mode=1, defaults:
  - Pixel 0 -> 0/0/0.
  - Pixel 80 -> b=F only.
  - Pixel 560 and 639 -> r=g=b=F.
  - Pixel 640 -> 0 (blanked).
- Tear-free switch: mode 2 -> 0 written at line 100 -> checkerboard continues to end of frame; solid_rgb=0x3A5 appears from next frame_start.
- Small config: H_ACTIVE=8, all porches/syncs 1 or 2, V_ACTIVE=4, CLK_DIV=3, SYNC_NEG=0.
  - Each output held 3 clks.
  - Syncs active-high.
  - Run 256 frames -> frame_count wraps 255 -> 0.
  - Gradient r increments by 1 per frame at pixel (0,0).
